// File: rtl/aes_pkg.sv
// Shared AES MixColumns definitions: GF(2^8) helpers, state width, FSM states.
// Imported by mix_column_unit and mix_columns_iter.
package aes_pkg;

    localparam int STATE_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_e;

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Multiply by a 4-bit constant (02, 03, 09, 0B, 0D, 0E) via xtime chain.
    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [3:0] k);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (k[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational (Inv)MixColumns on one 32-bit column; byte r at [8r+:8].
// Ports: col_i column in, inverse_i mode select, col_o transformed column.
module mix_column_unit
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [31:0] col_i,
    input  logic        inverse_i,
    output logic [31:0] col_o
);

    logic [7:0] a [4];
    logic [7:0] fwd;
    logic [7:0] inv;

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r] = col_i[8*r +: 8];
        end
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            // Circulant matrix: row r is row 0 rotated right by r.
            fwd = gf_mul(a[r], 4'h2)
                ^ gf_mul(a[(r+1)%4], 4'h3)
                ^ a[(r+2)%4]
                ^ a[(r+3)%4];
            inv = gf_mul(a[r], 4'hE)
                ^ gf_mul(a[(r+1)%4], 4'hB)
                ^ gf_mul(a[(r+2)%4], 4'hD)
                ^ gf_mul(a[(r+3)%4], 4'h9);
            col_o[8*r +: 8] = (INV_EN && inverse_i) ? inv : fwd;
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES (Inv)MixColumns over a 128-bit state, COLS_PER_CYCLE columns
// per cycle. Ports: clk, rst (sync, active-low), in_valid/in_ready + state +
// inverse input handshake, out_valid/out_ready + state_out result, busy.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] state,
    input  logic               inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 ||
          COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam int STEPS = 4 / COLS_PER_CYCLE;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    fsm_e               state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               inv_q;
    logic               out_valid_q;
    logic [STATE_W-1:0] work_q;
    logic [STATE_W-1:0] work_d;

    logic [31:0] col_in  [COLS_PER_CYCLE];
    logic [31:0] col_out [COLS_PER_CYCLE];

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
        assign col_in[g] =
            work_q[32*(int'(cnt_q)*COLS_PER_CYCLE + g) +: 32];

        mix_column_unit #(
            .INV_EN(INV_EN)
        ) u_col (
            .col_i    (col_in[g]),
            .inverse_i(inv_q),
            .col_o    (col_out[g])
        );
    end

    // Working register with the current column group replaced.
    always_comb begin
        work_d = work_q;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            work_d[32*(int'(cnt_q)*COLS_PER_CYCLE + g) +: 32] = col_out[g];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            work_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q  <= state;
                        inv_q   <= inverse & INV_EN;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work_q <= work_d;
                    // Counter holds on the last step; it never wraps.
                    if (cnt_q == LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = rst & (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign state_out = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Testbench for mix_columns_iter: one DUT per legal COLS_PER_CYCLE (1, 2, 4),
// checked against a matrix-product GF(2^8) reference model.
module tb_mix_columns_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         iv   [3];
    logic         ir   [3];
    logic         inv  [3];
    logic         ov   [3];
    logic         ordy [3];
    logic         bz   [3];
    logic [127:0] st   [3];
    logic [127:0] so   [3];

    int checks   = 0;
    int failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_iter #(
            .COLS_PER_CYCLE(1 << g),
            .INV_EN        (1'b1)
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .state    (st[g]),
            .inverse  (inv[g]),
            .out_valid(ov[g]),
            .out_ready(ordy[g]),
            .state_out(so[g]),
            .busy     (bz[g])
        );
    end

    // Carry-less product then polynomial reduction by 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mc(input logic [127:0] s,
                                            input bit m);
        logic [7:0]   row0 [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (m) row0 = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else   row0 = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(row0[(j - r + 4) % 4],
                                     s[8*(4*c + j) +: 8]);
                o[8*(4*c + r) +: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_job(input int d, input logic [127:0] s,
                           input bit m, input logic [127:0] exp,
                           input int stall, input string name);
        int lat;
        @(negedge clk);
        st[d] = s;
        inv[d] = m;
        iv[d] = 1'b1;
        checks++;
        if (ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s d=%0d in_ready=%b want 1", name, d, ir[d]);
        end
        @(posedge clk);
        #1;
        // Ignored while not in IDLE.
        st[d] = rnd128();
        inv[d] = ~m;
        lat = 1;
        while (ov[d] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 4 / (1 << d) + 1) begin
            failures++;
            $display("FAIL %s d=%0d latency=%0d want %0d",
                     name, d, lat, 4 / (1 << d) + 1);
        end
        checks++;
        if (so[d] !== exp) begin
            failures++;
            $display("FAIL %s d=%0d state_out=%h want %h",
                     name, d, so[d], exp);
        end
        repeat (stall) begin
            @(posedge clk);
            #1;
            checks++;
            if (ov[d] !== 1'b1 || so[d] !== exp || ir[d] !== 1'b0) begin
                failures++;
                $display("FAIL %s_stall d=%0d ov=%b ir=%b out=%h want %h",
                         name, d, ov[d], ir[d], so[d], exp);
            end
        end
        iv[d] = 1'b0;
        ordy[d] = 1'b1;
        @(posedge clk);
        #1;
        ordy[d] = 1'b0;
        checks++;
        if (ov[d] !== 1'b0 || ir[d] !== 1'b1) begin
            failures++;
            $display("FAIL %s_release d=%0d ov=%b ir=%b want 0/1",
                     name, d, ov[d], ir[d]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b1;
            st[d] = rnd128();
            inv[d] = 1'b1;
            ordy[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b0 || ov[d] !== 1'b0 || bz[d] !== 1'b0 ||
                so[d] !== 128'h0) begin
                failures++;
                $display("FAIL reset d=%0d ir=%b ov=%b busy=%b out=%h",
                         d, ir[d], ov[d], bz[d], so[d]);
            end
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ir[d] !== 1'b1 || bz[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_release d=%0d ir=%b busy=%b want 1/0",
                         d, ir[d], bz[d]);
            end
        end
    endtask

    task automatic test_vectors();
        for (int d = 0; d < 3; d++) begin
            run_job(d, {96'h0, 32'h4553_13DB}, 1'b0,
                    {96'h0, 32'hBCA1_4D8E}, 0, "fwd_vec");
            run_job(d, {96'h0, 32'hBCA1_4D8E}, 1'b1,
                    {96'h0, 32'h4553_13DB}, 0, "inv_vec");
            run_job(d, {32'h5C22_0AF2, 96'h0}, 1'b0,
                    {32'h9D58_DC9F, 96'h0}, 1, "fwd_vec2");
            run_job(d, {32'h9D58_DC9F, 96'h0}, 1'b1,
                    {32'h5C22_0AF2, 96'h0}, 0, "inv_vec2");
        end
    endtask

    task automatic test_identity();
        logic [127:0] id;
        id = {32'h0101_0101, 32'hC6C6_C6C6, 32'hC6C6_C6C6, 32'h0101_0101};
        for (int d = 0; d < 3; d++) begin
            run_job(d, id, 1'b0, id, 0, "ident_fwd");
            run_job(d, id, 1'b1, id, 0, "ident_inv");
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] a;
        logic [127:0] b;
        int lat;
        a = rnd128();
        b = rnd128();
        @(negedge clk);
        st[0] = a;
        inv[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        st[0] = b;
        inv[0] = 1'b1;
        lat = 1;
        while (ov[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            checks++;
            if (ov[0] !== 1'b1 || ir[0] !== 1'b0 ||
                so[0] !== ref_mc(a, 1'b0)) begin
                failures++;
                $display("FAIL b2b_hold ov=%b ir=%b out=%h want %h",
                         ov[0], ir[0], so[0], ref_mc(a, 1'b0));
            end
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        checks++;
        if (ov[0] !== 1'b0 || ir[0] !== 1'b1 || bz[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle ov=%b ir=%b busy=%b want 0/1/0",
                     ov[0], ir[0], bz[0]);
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        checks++;
        if (bz[0] !== 1'b1 || ir[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept busy=%b ir=%b want 1/0", bz[0], ir[0]);
        end
        lat = 1;
        while (ov[0] !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 5 || so[0] !== ref_mc(b, 1'b1)) begin
            failures++;
            $display("FAIL b2b_second lat=%0d out=%h want 5 %h",
                     lat, so[0], ref_mc(b, 1'b1));
        end
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
    endtask

    task automatic test_abort();
        logic [127:0] s;
        s = rnd128();
        @(negedge clk);
        st[0] = s;
        inv[0] = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (ov[0] !== 1'b0 || bz[0] !== 1'b0 || ir[0] !== 1'b0 ||
            so[0] !== 128'h0) begin
            failures++;
            $display("FAIL abort ov=%b busy=%b ir=%b out=%h",
                     ov[0], bz[0], ir[0], so[0]);
        end
        rst = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
                failures++;
                $display("FAIL abort_quiet ov=%b ir=%b want 0/1",
                         ov[0], ir[0]);
            end
        end
        s = rnd128();
        run_job(0, s, 1'b1, ref_mc(s, 1'b1), 0, "abort_fresh");
    endtask

    task automatic test_random();
        logic [127:0] s;
        bit           m;
        for (int i = 0; i < 1000; i++) begin
            s = rnd128();
            m = 1'($urandom_range(0, 1));
            run_job(i % 3, s, m, ref_mc(s, m),
                    int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0;
            inv[d] = 1'b0;
            ordy[d] = 1'b0;
            st[d] = '0;
        end
        rst = 1'b0;
        test_reset();
        test_vectors();
        test_identity();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mix_columns_iter.md
MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, columns processed per compute cycle; legal values 1, 2, 4; any other value SHALL fail elaboration.
REQ-002 Parameter INV_EN, default 1, inverse MixColumns support; 0 removes inverse logic and forces forward mode.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input state offered.
REQ-006 in_ready  output  1  block can accept a state.
REQ-007 state  input  128  input state; byte (4c+r) at bits [8*(4c+r)+:8], column c, row r.
REQ-008 inverse  input  1  sampled with state: 0 = MixColumns, 1 = InvMixColumns.
REQ-009 out_valid  output  1  state_out holds a result.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 state_out  output  128  result, same byte mapping as state.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-014 in_ready SHALL be high only in IDLE; an accept is in_valid & in_ready.
REQ-015 On accept, the block SHALL latch state into a working register, latch inverse (forced 0 if INV_EN=0), clear the column counter, and go to RUN.
REQ-016 In RUN, each cycle SHALL replace columns [k*COLS_PER_CYCLE, (k+1)*COLS_PER_CYCLE) of the working register with their transform, where k is the counter, then increment k.
REQ-017 RUN SHALL last exactly 4/COLS_PER_CYCLE cycles, then go to DONE; accept-to-out_valid latency SHALL be 4/COLS_PER_CYCLE+1 cycles (5, 3 or 2).
REQ-018 Forward transform per column: out = M·in over GF(2^8) with poly 0x11B; M rows {02 03 01 01}, {01 02 03 01}, {01 01 02 03}, {03 01 01 02}.
REQ-019 Inverse transform per column: M rows {0E 0B 0D 09}, {09 0E 0B 0D}, {0D 09 0E 0B}, {0B 0D 09 0E}.
REQ-020 xtime SHALL be a left shift by one, XORed with 0x1B when the input MSB is 1; results SHALL be truncated to 8 bits.
REQ-021 In DONE, out_valid SHALL be 1 and state_out SHALL equal the working register; state_out SHALL stay stable while out_valid & !out_ready.
REQ-022 When out_valid & out_ready, the block SHALL go to IDLE in the next cycle; no new accept in the same cycle (maximum throughput is one state per latency+1 cycles).
REQ-023 in_valid SHALL be ignored in RUN and DONE; state and inverse changes outside an accept SHALL have no effect.
REQ-024 The counter SHALL be log2(4/COLS_PER_CYCLE) bits (minimum 1); it SHALL not wrap inside a job, and RUN SHALL exit on the last count.
REQ-025 out_ready while out_valid is low SHALL have no effect.

Reset
REQ-026 When rst is low at a clock edge, the next state SHALL be: FSM IDLE, in_ready 1 (after reset release), out_valid 0, busy 0, state_out 0, counter 0, latched mode 0.
REQ-027 Reset during RUN or DONE SHALL abort the job; the partial result SHALL never be presented.
REQ-028 While rst is low, in_ready SHALL be 0 and no accept SHALL occur.

Structure
REQ-029 Shared package aes_pkg SHALL hold the xtime and gf_mul functions (by 02, 03, 09, 0B, 0D, 0E), the state-width constant 128, and the FSM state enum.
REQ-030 Sub-module mix_column_unit (32-bit column in, 32-bit out, inverse input) SHALL be instantiated COLS_PER_CYCLE times via generate.

Verification
REQ-031 Forward, COLS_PER_CYCLE=1: column 0 = 32'h4553_13DB, others 0 -> column 0 = 32'hBCA1_4D8E, others 0; out_valid exactly 5 cycles after accept.
REQ-032 Inverse, all widths: column 32'hBCA1_4D8E -> 32'h4553_13DB; column 32'h5C22_0AF2 forward -> 32'h9D58_DC9F, inverse round-trips.
REQ-033 Identity columns 32'h0101_0101 and 32'hC6C6_C6C6 SHALL be unchanged in both modes; latency is 3 for COLS_PER_CYCLE=2 and 2 for 4.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE -> state_out stable, in_ready 0; new in_valid ignored; the accept occurs in the cycle after the out_ready handshake.
REQ-035 Assert rst low during the 2nd RUN cycle -> the next cycle has out_valid 0 and IDLE; a fresh job then returns correct results.
REQ-036 Random regression, 1000 states, random mode and random out_ready, against a reference model for every legal COLS_PER_CYCLE -> no mismatch.
